// File: rtl/pulse_edge_detector_if.sv
// Lane bundle for the pulse/edge detector: sampled level inputs and the two
// per-lane combinational detection strobes.
interface pulse_edge_detector_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] posedge_detected;
    logic [WIDTH-1:0] pulse_detected;

    // Producer of the level lanes, consumer of the strobes.
    modport master (
        output a,
        input  posedge_detected,
        input  pulse_detected
    );

    // The detector itself.
    modport slave (
        input  a,
        output posedge_detected,
        output pulse_detected
    );
endinterface

// File: rtl/pulse_edge_detector.sv
// Per-lane rising-edge and isolated single-cycle-pulse detector.
// Each lane keeps a two-sample history; both detections are Mealy outputs
// built from the live input and that history, so they assert in the same
// cycle as the qualifying sample. Reset also masks the outputs so an
// undefined input while reset is held cannot reach them.
module pulse_edge_detector #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_edge_detector_if.slave  bus
);

    logic [WIDTH-1:0] a_d1;
    logic [WIDTH-1:0] a_d2;
    logic [WIDTH-1:0] run_mask;

    // Two-deep history per lane, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_d1 <= '0;
            a_d2 <= '0;
        end else begin
            a_d2 <= a_d1;
            a_d1 <= bus.a;
        end
    end

    // Detection strobes: 0->1 now, or a completed 0,1,0 pattern now.
    always_comb begin
        run_mask             = {WIDTH{~rst}};
        bus.posedge_detected = bus.a & ~a_d1 & run_mask;
        bus.pulse_detected   = ~bus.a & a_d1 & ~a_d2 & run_mask;
    end

endmodule

// File: tb/tb_pulse_edge_detector.sv
// Self-checking bench for pulse_edge_detector (WIDTH=4): directed scenarios
// plus randomized traffic compared against a sample-history reference model.
module tb_pulse_edge_detector;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pulse_edge_detector_if #(.WIDTH(W)) bus ();

    pulse_edge_detector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: every input vector sampled since reset release.
    logic [W-1:0] samples[$];

    function automatic logic [W-1:0] past(input int k);
        if (samples.size() >= k) return samples[samples.size() - k];
        return '0;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: present v, check the strobes against the model, then clock it in.
    task automatic step(input logic [W-1:0] v, input string tag,
                        output logic [W-1:0] pe, output logic [W-1:0] pd);
        logic [W-1:0] exp_pe;
        logic [W-1:0] exp_pd;
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        bus.a = v;
        #2;
        exp_pe = '0;
        exp_pd = '0;
        if (!rst) begin
            p1 = past(1);
            p2 = past(2);
            for (int i = 0; i < W; i++) begin
                exp_pe[i] = (v[i] === 1'b1) && (p1[i] == 1'b0);
                exp_pd[i] = (v[i] === 1'b0) && (p1[i] == 1'b1) && (p2[i] == 1'b0);
            end
        end
        pe = bus.posedge_detected;
        pd = bus.pulse_detected;
        check({tag, "_posedge"}, pe, exp_pe);
        check({tag, "_pulse"}, pd, exp_pd);
        check({tag, "_excl"}, pe & pd, '0);
        @(posedge clk);
        if (rst) samples.delete();
        else begin
            samples.push_back(v);
            if (samples.size() > 4) void'(samples.pop_front());
        end
        #1;
    endtask

    logic [W-1:0] pe;
    logic [W-1:0] pd;
    logic [15:0]  ref_seq;
    logic [15:0]  pe_l0, pd_l0, pe_l1, pd_l1, pe_l2, pd_l2, pe_l3, pd_l3;
    logic [W-1:0] v;

    initial begin
        bus.a = '0;
        @(posedge clk);
        #1;

        // Reset held: toggling and undefined inputs must give no strobes.
        step(4'hF, "rst_hold_ones", pe, pd);
        step(4'h0, "rst_hold_zeros", pe, pd);
        step('x, "rst_hold_x", pe, pd);
        step(4'hA, "rst_hold_alt", pe, pd);

        // Release with a=1 in the first cycle: immediate rising edge.
        rst = 1'b0;
        step(4'hF, "first_cycle_ones", pe, pd);
        check("first_cycle_direct", pe, 4'hF);
        step(4'h0, "after_first_high", pe, pd);
        check("after_first_pulse_direct", pd, 4'hF);

        // Reset asserted mid-cycle right after a=1 was sampled.
        step(4'h0, "pre_mid", pe, pd);
        step(4'b0101, "mid_high", pe, pd);
        bus.a = '0;
        #1;
        rst = 1'b1;
        #1;
        samples.delete();
        check("mid_rst_posedge", bus.posedge_detected, '0);
        check("mid_rst_pulse", bus.pulse_detected, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'h0, "after_mid_rst", pe, pd);
        check("after_mid_rst_no_pulse", pd, '0);

        // Multi-lane directed: reference / zero / one / alternation, fresh after reset.
        rst = 1'b1;
        step(4'h0, "rst_before_ref", pe, pd);
        rst = 1'b0;
        ref_seq = 16'b1000_1110_0100_0100; // bit n = a at cycle n
        for (int c = 0; c < 16; c++) begin
            v[0] = ref_seq[c];
            v[1] = 1'b0;
            v[2] = 1'b1;
            v[3] = c[0];
            step(v, "multilane", pe, pd);
            pe_l0[c] = pe[0]; pd_l0[c] = pd[0];
            pe_l1[c] = pe[1]; pd_l1[c] = pd[1];
            pe_l2[c] = pe[2]; pd_l2[c] = pd[2];
            pe_l3[c] = pe[3]; pd_l3[c] = pd[3];
        end
        check16("ref_posedge_cycles", pe_l0, 16'h8244);
        check16("ref_pulse_cycles", pd_l0, 16'h0088);
        check16("zero_lane_posedge", pe_l1, 16'h0000);
        check16("zero_lane_pulse", pd_l1, 16'h0000);
        check16("one_lane_posedge", pe_l2, 16'h0001);
        check16("one_lane_pulse", pd_l2, 16'h0000);
        check16("alt_posedge_cycles", pe_l3, 16'hAAAA);
        check16("alt_pulse_cycles", pd_l3, 16'h5554);

        // Long high run 0,1,1,1,1,0 on all lanes.
        for (int c = 0; c < 6; c++) begin
            v = (c == 0 || c == 5) ? 4'h0 : 4'hF;
            step(v, "long_run", pe, pd);
        end

        // Randomized traffic with occasional reset cycles.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 31) == 0);
            step(W'($urandom), "random", pe, pd);
        end
        rst = 1'b0;
        step(4'h0, "final", pe, pd);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_edge_detector.md
Name: pulse_edge_detector

Overview:
- Per-channel detector for rising edges and isolated single-cycle high pulses on synchronous 1-bit input lanes.
- Each lane has a 2-deep history shift register. Both detections are combinational (Mealy) from the current input and that history, so they assert in the same cycle as the qualifying input sample.
- Used as a building block for event/strobe extraction from level signals already in the clk domain.
- Contains both detection functions, rising-edge and one-cycle-pulse, side by side for every lane.

Parameters:
- WIDTH, 1, number of independent input lanes; each lane is processed identically, with no cross-lane interaction.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears all history registers.
- a  input  WIDTH  input lanes; synchronous to clk, stable around the rising edge.
- posedge_detected  output  WIDTH  bit i high when lane i shows a 0->1 transition at the current sample.
- pulse_detected  output  WIDTH  bit i high when lane i has just completed a 0,1,0 pattern.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk and rst).
- State per lane:
  - a_d1: a sampled at the previous rising edge.
  - a_d2: a_d1 sampled at the previous rising edge.
- On each rising clk edge (rst low): a_d2 <= a_d1; a_d1 <= a.
- On rst high (asynchronous, no clock needed): a_d1 = 0, a_d2 = 0, for all lanes. They stay 0 while rst is held.
- posedge_detected[i] = a[i] & ~a_d1[i] & ~rst.
- pulse_detected[i] = ~a[i] & a_d1[i] & ~a_d2[i] & ~rst.
- Latency:
  - posedge_detected is zero-cycle, i.e. combinational from a within the cycle the new value is presented. It must be valid before the rising edge that samples that value.
  - pulse_detected asserts in the cycle where a returns to 0, one cycle after the single high sample.
- Each output pulse lasts exactly one clock cycle per event; outputs are never registered.
- Boundary rules:
  - First cycle after reset release: history is 0. If a=1 in that cycle, posedge_detected=1. A 1,0 sequence starting right after reset yields pulse_detected=1 in the 0 cycle, because a_d2 = 0.
  - High run of length >= 2 (0,1,1,...,0): posedge_detected fires once, at the first 1; pulse_detected never fires.
  - Alternating 0,1,0,1,0: posedge_detected on every 1; pulse_detected on every 0 that follows a 1. pulse_detected[n] and posedge_detected[n+1] occur in consecutive cycles and never in the same cycle.
  - posedge_detected and pulse_detected on the same lane are mutually exclusive in any cycle, since they require opposite values of a.
  - Reset mid-operation: outputs drop to 0 immediately and history clears. After release, detection restarts as from the first-cycle rule.
  - X on a while rst is high must not propagate into history or outputs.
- No other state, counters or handshakes.

Test Plan:
- Reference sequence, WIDTH=1, rst released, one a value per cycle, cycles 0..15: a = 0,0,1,0,0,0,1,0,0,1,1,1,0,0,0,1.
  - posedge_detected high only at cycles 2, 6, 9, 15.
  - pulse_detected high only at cycles 3 and 7.
- Long high run: a = 0,1,1,1,1,0 -> posedge_detected only in cycle 1; pulse_detected never asserts.
- Alternation: a = 0,1,0,1,0,1,0 -> posedge_detected at cycles 1, 3, 5; pulse_detected at cycles 2, 4, 6; never both in one cycle.
- Reset behaviour:
  - Hold rst high with a toggling or X -> both outputs 0 throughout.
  - Release with a=1 in the first cycle -> posedge_detected=1 in that cycle.
  - Assert rst mid-pulse, with a=1 just sampled -> outputs 0 immediately, and no pulse_detected after release when a=0.
- Multi-lane, WIDTH=4: lane 0 gets the reference sequence, lane 1 stays at 0, lane 2 stays at 1, lane 3 gets the alternation sequence.
  - Lane 0 and lane 3 responses match the scenarios above.
  - Lane 1: no outputs.
  - Lane 2: posedge_detected only in the first cycle after reset, then no outputs.
